// File: rtl/inst_mem_fetch.sv
// Instruction memory with a clear/load/fetch front end.
// CLEAR zeroes the array after reset. LOAD writes the program. IDLE/RUN serve one fetch per cycle.
module inst_mem_fetch #(
    parameter int          DATA_W  = 16,
    parameter int          ADDR_W  = 8,
    parameter int          DEPTH   = 128,
    parameter logic [3:0]  HALT_OP = 4'hE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              load_we,
    input  logic [ADDR_W-2:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    input  logic              inst_stall,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_out,
    output logic [1:0]        fault_code,
    output logic              halted,
    output logic              busy
);

    localparam int                AW_M      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned       LAST_I    = DEPTH - 1;
    localparam logic [AW_M-1:0]   CLR_LAST  = LAST_I[AW_M-1:0];
    localparam logic [AW_M-1:0]   CLR_ONE   = AW_M'(1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [1:0]        F_OK      = 2'b00;
    localparam logic [1:0]        F_MIS     = 2'b01;
    localparam logic [1:0]        F_OOR     = 2'b10;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t            state_r;
    logic [AW_M-1:0]   clr_cnt_r;
    logic [DATA_W-1:0] mem_r [0:DEPTH-1];
    logic              inst_valid_r;
    logic [DATA_W-1:0] inst_out_r;
    logic [1:0]        fault_r;
    logic              halted_r;

    logic              active_s;
    logic              stall_s;
    logic              ready_s;
    logic              go_load_s;
    logic              accept_s;
    logic [ADDR_W-2:0] idx_s;
    logic [1:0]        fault_s;
    logic [DATA_W-1:0] data_s;
    logic              halt_hit_s;
    logic              ld_ok_s;

    // Handshake decode and fetch result lookup; misalignment is checked before range.
    always_comb begin
        active_s   = (state_r == ST_IDLE) || (state_r == ST_RUN);
        stall_s    = inst_valid_r && inst_stall;
        ready_s    = active_s && !load_en && !halted_r && !stall_s;
        go_load_s  = active_s && load_en && !stall_s;
        accept_s   = ready_s && fetch_req;
        idx_s      = fetch_addr[ADDR_W-1:1];
        ld_ok_s    = ({1'b0, load_addr} < DEPTH_A);
        if (fetch_addr[0]) begin
            fault_s = F_MIS;
            data_s  = '0;
        end else if ({1'b0, idx_s} >= DEPTH_A) begin
            fault_s = F_OOR;
            data_s  = '0;
        end else begin
            fault_s = F_OK;
            data_s  = mem_r[idx_s[AW_M-1:0]];
        end
        halt_hit_s = (fault_s == F_OK) && (data_s[DATA_W-1 -: 4] == HALT_OP);
    end

    // Memory write port shared by the clear sweep and program load; no reset on the array itself.
    always_ff @(posedge clk) begin
        if (rst_n && (state_r == ST_CLEAR)) begin
            mem_r[clr_cnt_r] <= '0;
        end else if (rst_n && (state_r == ST_LOAD) && load_we && ld_ok_s) begin
            mem_r[load_addr[AW_M-1:0]] <= load_data;
        end
    end

    // Control FSM with registered instruction output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_CLEAR;
            clr_cnt_r    <= '0;
            inst_valid_r <= 1'b0;
            inst_out_r   <= '0;
            fault_r      <= F_OK;
            halted_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    inst_valid_r <= 1'b0;
                    if (clr_cnt_r == CLR_LAST) begin
                        state_r <= ST_IDLE;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + CLR_ONE;
                    end
                end
                ST_LOAD: begin
                    if (!load_en) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE, ST_RUN: begin
                    if (go_load_s) begin
                        state_r      <= ST_LOAD;
                        halted_r     <= 1'b0;
                        inst_valid_r <= 1'b0;
                    end else if (accept_s) begin
                        state_r      <= ST_RUN;
                        inst_valid_r <= 1'b1;
                        inst_out_r   <= data_s;
                        fault_r      <= fault_s;
                        if (halt_hit_s) begin
                            halted_r <= 1'b1;
                        end
                    end else if (!stall_s) begin
                        inst_valid_r <= 1'b0;
                        // RUN drains back to IDLE once the output is empty and no one asks.
                        if ((state_r == ST_RUN) && !inst_valid_r && !fetch_req) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_cnt_r <= '0;
                end
            endcase
        end
    end

    assign fetch_ready = ready_s;
    assign inst_valid  = inst_valid_r;
    assign inst_out    = inst_out_r;
    assign fault_code  = fault_r;
    assign halted      = halted_r;
    assign busy        = (state_r == ST_CLEAR) || (state_r == ST_LOAD);

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Directed bench for inst_mem_fetch: two instances (DEPTH 128 and 16) share stimulus,
// a behavioural model predicts both every cycle, and literal checks pin key results.
module tb_inst_mem_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en, load_we, fetch_req, inst_stall;
    logic [6:0]  load_addr;
    logic [15:0] load_data;
    logic [7:0]  fetch_addr;

    logic        rdy0, val0, hlt0, bsy0, rdy1, val1, hlt1, bsy1;
    logic [15:0] out0, out1;
    logic [1:0]  flt0, flt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inst_mem_fetch u0 (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .fetch_req(fetch_req),
        .fetch_addr(fetch_addr), .fetch_ready(rdy0), .inst_stall(inst_stall),
        .inst_valid(val0), .inst_out(out0), .fault_code(flt0), .halted(hlt0), .busy(bsy0)
    );

    inst_mem_fetch #(.DEPTH(16)) u1 (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .fetch_req(fetch_req),
        .fetch_addr(fetch_addr), .fetch_ready(rdy1), .inst_stall(inst_stall),
        .inst_valid(val1), .inst_out(out1), .fault_code(flt1), .halted(hlt1), .busy(bsy1)
    );

    // Behavioural model: memory image, clear countdown, load flag, output register, halt flag.
    int          dep [2] = '{128, 16};
    logic [15:0] mm [2][128];
    int          clr_left [2];
    bit          ld_m [2];
    bit          v_m [2];
    logic [15:0] d_m [2];
    logic [1:0]  f_m [2];
    bit          h_m [2];
    bit          started = 1'b0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[u%0d] t=%0t got=%0h want=%0h", nm, k, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                clr_left[k] = dep[k];
                ld_m[k] = 1'b0; v_m[k] = 1'b0; d_m[k] = 16'h0; f_m[k] = 2'b00; h_m[k] = 1'b0;
            end else if (clr_left[k] > 0) begin
                mm[k][dep[k] - clr_left[k]] = 16'h0;
                clr_left[k]--;
            end else if (ld_m[k]) begin
                if (load_we && (int'(load_addr) < dep[k])) mm[k][int'(load_addr)] = load_data;
                if (!load_en) ld_m[k] = 1'b0;
            end else begin
                bit stl;
                stl = v_m[k] && inst_stall;
                if (load_en && !stl) begin
                    ld_m[k] = 1'b1; h_m[k] = 1'b0; v_m[k] = 1'b0;
                end else if (fetch_req && !h_m[k] && !stl) begin
                    int w;
                    w = int'(fetch_addr) / 2;
                    v_m[k] = 1'b1;
                    if (fetch_addr[0]) begin
                        f_m[k] = 2'b01; d_m[k] = 16'h0;
                    end else if (w >= dep[k]) begin
                        f_m[k] = 2'b10; d_m[k] = 16'h0;
                    end else begin
                        f_m[k] = 2'b00; d_m[k] = mm[k][w];
                        if (d_m[k][15:12] == 4'hE) h_m[k] = 1'b1;
                    end
                end else if (!stl) begin
                    v_m[k] = 1'b0;
                end
            end
        end
        if (!rst_n) started = 1'b1;
    end

    task automatic cmp(input int k, input logic v, input logic [15:0] o, input logic [1:0] f,
                       input logic h, input logic b, input logic r);
        bit er;
        er = (clr_left[k] == 0) && !ld_m[k] && !load_en && !h_m[k] && !(v_m[k] && inst_stall);
        chk("valid", k, {31'd0, v}, {31'd0, v_m[k]});
        if (v_m[k]) begin
            chk("inst_out", k, {16'd0, o}, {16'd0, d_m[k]});
            chk("fault", k, {30'd0, f}, {30'd0, f_m[k]});
        end
        chk("halted", k, {31'd0, h}, {31'd0, h_m[k]});
        chk("busy", k, {31'd0, b}, {31'd0, (clr_left[k] > 0) || ld_m[k]});
        chk("ready", k, {31'd0, r}, {31'd0, er});
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            cmp(0, val0, out0, flt0, hlt0, bsy0, rdy0);
            cmp(1, val1, out1, flt1, hlt1, bsy1, rdy1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic count_clear(input string nm);
        int n;
        n = 0;
        while (bsy0 && n < 300) begin
            cyc();
            n++;
        end
        chk(nm, 0, n, 128);
        chk({nm, "_ready"}, 0, {31'd0, rdy0}, 32'd1);
    endtask

    task automatic load_word(input logic [6:0] a, input logic [15:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; load_en = 1'b0; load_we = 1'b0; load_addr = 7'd0; load_data = 16'h0;
        fetch_req = 1'b0; fetch_addr = 8'h00; inst_stall = 1'b0;
        repeat (2) cyc();
        chk("rst_valid", 0, {31'd0, val0}, 32'd0);
        chk("rst_out", 0, {16'd0, out0}, 32'd0);
        chk("rst_fault", 0, {30'd0, flt0}, 32'd0);
        chk("rst_halted", 0, {31'd0, hlt0}, 32'd0);
        chk("rst_ready", 0, {31'd0, rdy0}, 32'd0);
        chk("rst_busy", 0, {31'd0, bsy0}, 32'd1);
        rst_n = 1'b1;
        count_clear("clear_len");

        fetch_req = 1'b1; fetch_addr = 8'h00;
        cyc();
        chk("first_fetch", 0, {16'd0, out0}, 32'h0000);
        chk("first_valid", 0, {31'd0, val0}, 32'd1);
        fetch_req = 1'b0;

        // Program load; word 0x19 lands in u0 only (out of range for u1).
        load_en = 1'b1;
        cyc();
        chk("load_busy", 0, {31'd0, bsy0}, 32'd1);
        load_word(7'd0, 16'h012F);
        load_word(7'd1, 16'h012E);
        load_word(7'h19, 16'hEFFF);
        load_word(7'd20, 16'hAAAA);
        load_we = 1'b0; load_en = 1'b0;
        cyc();

        fetch_req = 1'b1; fetch_addr = 8'h00;
        cyc();
        chk("b2b_0", 0, {16'd0, out0}, 32'h012F);
        fetch_addr = 8'h02;
        cyc();
        chk("b2b_1", 0, {16'd0, out0}, 32'h012E);
        chk("b2b_fault", 0, {30'd0, flt0}, 32'd0);
        fetch_addr = 8'h03;
        cyc();
        chk("misalign_out", 0, {16'd0, out0}, 32'h0);
        chk("misalign_fault", 0, {30'd0, flt0}, 32'd1);
        fetch_addr = 8'h20;
        cyc();
        chk("oor_fault", 1, {30'd0, flt1}, 32'd2);
        chk("oor_halt", 1, {31'd0, hlt1}, 32'd0);
        fetch_addr = 8'h28;
        cyc();
        chk("u0_word20", 0, {16'd0, out0}, 32'hAAAA);

        // Stall hold, then resume on the cycle the stall drops.
        fetch_addr = 8'h00;
        cyc();
        inst_stall = 1'b1; fetch_addr = 8'h02;
        #1 chk("stall_ready", 0, {31'd0, rdy0}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_hold", 0, {16'd0, out0}, 32'h012F);
            chk("stall_valid", 0, {31'd0, val0}, 32'd1);
        end
        inst_stall = 1'b0;
        #1 chk("unstall_ready", 0, {31'd0, rdy0}, 32'd1);
        cyc();
        chk("resume", 0, {16'd0, out0}, 32'h012E);
        fetch_req = 1'b0;
        cyc();

        // Halt word delivery, refused fetch, and clear via load_en.
        fetch_req = 1'b1; fetch_addr = 8'h32;
        cyc();
        chk("halt_out", 0, {16'd0, out0}, 32'hEFFF);
        chk("halt_flag", 0, {31'd0, hlt0}, 32'd1);
        chk("halt_u1_fault", 1, {30'd0, flt1}, 32'd2);
        fetch_addr = 8'h00;
        #1 chk("halt_ready", 0, {31'd0, rdy0}, 32'd0);
        cyc();
        chk("halt_noaccept", 0, {31'd0, val0}, 32'd0);
        fetch_req = 1'b0; load_en = 1'b1;
        cyc();
        chk("halt_cleared", 0, {31'd0, hlt0}, 32'd0);
        load_en = 1'b0;
        cyc();

        // Load has priority over a simultaneous fetch.
        load_en = 1'b1; fetch_req = 1'b1; fetch_addr = 8'h00;
        #1 chk("prio_ready", 0, {31'd0, rdy0}, 32'd0);
        cyc();
        chk("prio_valid", 0, {31'd0, val0}, 32'd0);
        chk("prio_busy", 0, {31'd0, bsy0}, 32'd1);
        fetch_req = 1'b0;
        load_word(7'd5, 16'h1234);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; load_en = 1'b0; load_we = 1'b0;
        repeat (50) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        count_clear("reclear_len");

        // Full readback after the restarted clear.
        fetch_req = 1'b1;
        for (int i = 0; i < 128; i++) begin
            fetch_addr = 8'(2 * i);
            cyc();
            if (i == 0 || i == 5 || i == 25) chk("readback_zero", 0, {16'd0, out0}, 32'h0);
        end
        fetch_req = 1'b0;
        cyc();
        chk("final_halt", 0, {31'd0, hlt0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
